// File: rtl/lc3b_mem_responder.sv
// LC-3b memory-port responder: word RAM with byte-lane writes, fixed-latency
// single-cycle mem_resp, and a backdoor full-word preload port.
module lc3b_mem_responder #(
  parameter int unsigned ADDR_WORDS_LOG2 = 8,
  parameter int unsigned LATENCY         = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mem_read,
  input  logic                       mem_write,
  input  logic [1:0]                 mem_wmask,
  input  logic [15:0]                mem_address,
  input  logic [15:0]                mem_wdata,
  output logic [15:0]                mem_rdata,
  output logic                       mem_resp,
  input  logic                       preload_we,
  input  logic [ADDR_WORDS_LOG2-1:0] preload_addr,
  input  logic [15:0]                preload_data
);

  localparam int unsigned AW    = ADDR_WORDS_LOG2;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = 4;
  localparam int unsigned DW    = 16;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [1:0]      wmask_q, wmask_d;
  logic            is_wr_q, is_wr_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            resp_q, resp_d;
  logic [DW-1:0]   mem_q [DEPTH];

  // Commit operands: live inputs for a LATENCY=1 accept, captured copies otherwise
  logic            commit_c;
  logic [AW-1:0]   cm_addr_c;
  logic [DW-1:0]   cm_wdata_c;
  logic [1:0]      cm_wmask_c;
  logic            cm_wr_c;
  logic [DW-1:0]   cur_word_c;
  logic [DW-1:0]   merged_c;
  logic            unused_addr_c;

  assign unused_addr_c = ^{mem_address[15:AW+1], mem_address[0]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    is_wr_d    = is_wr_q;
    rdata_d    = rdata_q;
    resp_d     = 1'b0;
    commit_c   = 1'b0;
    cm_addr_c  = addr_q;
    cm_wdata_c = wdata_q;
    cm_wmask_c = wmask_q;
    cm_wr_c    = is_wr_q;

    case (state_q)
      S_IDLE: begin
        if (mem_read || mem_write) begin
          addr_d  = mem_address[AW:1];
          wdata_d = mem_wdata;
          wmask_d = mem_wmask;
          is_wr_d = mem_write;
          if (LATENCY <= 1) begin
            state_d    = S_RESP;
            commit_c   = 1'b1;
            cm_addr_c  = mem_address[AW:1];
            cm_wdata_c = mem_wdata;
            cm_wmask_c = mem_wmask;
            cm_wr_c    = mem_write;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CW'(LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == CW'(1)) begin
          state_d  = S_RESP;
          cnt_d    = '0;
          commit_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    cur_word_c = mem_q[cm_addr_c];
    merged_c   = {cm_wmask_c[1] ? cm_wdata_c[15:8] : cur_word_c[15:8],
                  cm_wmask_c[0] ? cm_wdata_c[7:0]  : cur_word_c[7:0]};
    if (commit_c) begin
      resp_d = 1'b1;
      if (!cm_wr_c) rdata_d = cur_word_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      is_wr_q <= 1'b0;
      rdata_q <= '0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      is_wr_q <= is_wr_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
    end
  end

  // Array is never cleared; the CPU write is issued last so it wins a same-word collision
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (preload_we) mem_q[preload_addr] <= preload_data;
      if (commit_c && cm_wr_c) mem_q[cm_addr_c] <= merged_c;
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_resp  = resp_q;

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Directed bench: LATENCY=3 instance for protocol/byte-lane/reset checks,
// LATENCY=1 instance for back-to-back throughput and address aliasing.
module tb_lc3b_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [1:0]  mem_wmask;
  logic [15:0] mem_address, mem_wdata, mem_rdata;
  logic        mem_resp;
  logic        preload_we;
  logic [7:0]  preload_addr;
  logic [15:0] preload_data;

  logic        read1;
  logic [15:0] addr1, rdata1;
  logic        resp1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lc3b_mem_responder #(.ADDR_WORDS_LOG2(8), .LATENCY(3)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wmask(mem_wmask), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .preload_we(preload_we),
    .preload_addr(preload_addr), .preload_data(preload_data)
  );

  lc3b_mem_responder #(.ADDR_WORDS_LOG2(8), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .mem_read(read1), .mem_write(1'b0),
    .mem_wmask(2'b00), .mem_address(addr1), .mem_wdata(16'h0000),
    .mem_rdata(rdata1), .mem_resp(resp1), .preload_we(preload_we),
    .preload_addr(preload_addr), .preload_data(preload_data)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  m;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    preload_we   = 1'b1;
    preload_addr = a;
    preload_data = d;
    tick();
    preload_we   = 1'b0;
  endtask

  // Issue one request on the LATENCY=3 instance; resp expected on the 3rd edge
  task automatic do_txn(input logic rd, input logic wr, input logic [1:0] m,
                        input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] exp, input string nm);
    int n;
    bit seen;
    mem_read    = rd;
    mem_write   = wr;
    mem_wmask   = m;
    mem_address = a;
    mem_wdata   = d;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      tick();
      n++;
      if (mem_resp === 1'b1) seen = 1'b1;
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    chk({nm, " latency"}, 32'(n), 32'd3);
    chk({nm, " rdata"}, 32'(mem_rdata), 32'(exp));
    tick();
    chk({nm, " single pulse"}, 32'(mem_resp), 32'd0);
    chk({nm, " rdata held"}, 32'(mem_rdata), 32'(exp));
  endtask

  initial begin
    int n;
    bit seen;

    tbl[0]  = '{1'b1, 1'b0, 2'b00, 16'h0020, 16'h0000, 16'hBEEF};
    tbl[1]  = '{1'b0, 1'b1, 2'b01, 16'h0021, 16'h1234, 16'hBEEF};
    tbl[2]  = '{1'b1, 1'b0, 2'b00, 16'h0020, 16'h0000, 16'hBE34};
    tbl[3]  = '{1'b0, 1'b1, 2'b10, 16'h0020, 16'hAB00, 16'hBE34};
    tbl[4]  = '{1'b1, 1'b0, 2'b00, 16'h0020, 16'h0000, 16'hAB34};
    tbl[5]  = '{1'b0, 1'b1, 2'b00, 16'h0020, 16'hFFFF, 16'hAB34};
    tbl[6]  = '{1'b1, 1'b0, 2'b00, 16'h0020, 16'h0000, 16'hAB34};
    tbl[7]  = '{1'b0, 1'b1, 2'b11, 16'h0222, 16'h5A5A, 16'hAB34};
    tbl[8]  = '{1'b1, 1'b0, 2'b00, 16'h0022, 16'h0000, 16'h5A5A};
    tbl[9]  = '{1'b1, 1'b1, 2'b11, 16'h0020, 16'h7777, 16'h5A5A};
    tbl[10] = '{1'b1, 1'b0, 2'b00, 16'h0020, 16'h0000, 16'h7777};
    tbl[11] = '{1'b1, 1'b0, 2'b00, 16'h0030, 16'h0000, 16'h1111};

    reset = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; mem_wmask = 2'b00;
    mem_address = 16'h0000; mem_wdata = 16'h0000;
    preload_we = 1'b0; preload_addr = 8'h00; preload_data = 16'h0000;
    read1 = 1'b0; addr1 = 16'h0000;
    tick();
    tick();
    reset = 1'b0;

    // Reset values over 10 idle cycles
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("reset resp c%0d", i), 32'(mem_resp), 32'd0);
      chk($sformatf("reset rdata c%0d", i), 32'(mem_rdata), 32'd0);
    end
    chk("reset resp1", 32'(resp1), 32'd0);
    chk("reset rdata1", 32'(rdata1), 32'd0);

    preload(8'h10, 16'hBEEF);
    preload(8'h18, 16'h1111);

    // LATENCY=1: held read pulses every other cycle; 0x0220 aliases word 0x10
    read1 = 1'b1;
    addr1 = 16'h0220;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("b2b resp1 c%0d", i), 32'(resp1), (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i % 2 == 0) chk($sformatf("b2b rdata1 c%0d", i), 32'(rdata1), 32'hBEEF);
    end
    read1 = 1'b0;
    tick();
    tick();

    for (int i = 0; i < 12; i++)
      do_txn(tbl[i].rd, tbl[i].wr, tbl[i].m, tbl[i].a, tbl[i].d, tbl[i].exp,
             $sformatf("vec%0d", i));

    // Address change and read drop during WAIT are ignored
    mem_read = 1'b1;
    mem_address = 16'h0020;
    tick();
    mem_read = 1'b0;
    mem_address = 16'h0030;
    n = 1;
    seen = 1'b0;
    while (!seen && n < 20) begin
      tick();
      n++;
      if (mem_resp === 1'b1) seen = 1'b1;
    end
    chk("capture latency", 32'(n), 32'd3);
    chk("capture rdata", 32'(mem_rdata), 32'h7777);
    tick();
    chk("capture single pulse", 32'(mem_resp), 32'd0);

    // Preload in WAIT, and preload colliding with CPU write on the commit edge
    mem_write = 1'b1; mem_wmask = 2'b11;
    mem_address = 16'h0024; mem_wdata = 16'hC0DE;
    tick();
    mem_write = 1'b0;
    preload_we = 1'b1; preload_addr = 8'h13; preload_data = 16'h2468;
    tick();
    preload_addr = 8'h12; preload_data = 16'hDEAD;
    tick();
    preload_we = 1'b0;
    chk("collide resp", 32'(mem_resp), 32'd1);
    chk("collide rdata held", 32'(mem_rdata), 32'h7777);
    tick();
    do_txn(1'b1, 1'b0, 2'b00, 16'h0026, 16'h0000, 16'h2468, "preload wait");
    do_txn(1'b1, 1'b0, 2'b00, 16'h0024, 16'h0000, 16'hC0DE, "cpu wins");

    // Reset in WAIT discards write; preload during reset ignored
    mem_write = 1'b1; mem_wmask = 2'b11;
    mem_address = 16'h0020; mem_wdata = 16'h5555;
    tick();
    reset = 1'b1;
    preload_we = 1'b1; preload_addr = 8'h10; preload_data = 16'h9999;
    tick();
    chk("midreset resp", 32'(mem_resp), 32'd0);
    chk("midreset rdata", 32'(mem_rdata), 32'd0);
    reset = 1'b0;
    mem_write = 1'b0;
    preload_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("post reset resp c%0d", i), 32'(mem_resp), 32'd0);
    end
    do_txn(1'b1, 1'b0, 2'b00, 16'h0020, 16'h0000, 16'h7777, "old value");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
